// File: rtl/analog_switch_sequencer_if.sv
// Channel-select request handshake between the I/O decode logic and the
// analog switch sequencer.
interface analog_switch_sequencer_if;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_chan;
    logic       req_off;

    modport master (
        output req_valid,
        output req_chan,
        output req_off,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_chan,
        input  req_off,
        output req_ready
    );
endinterface

// File: rtl/analog_switch_sequencer.sv
// Break-before-make sequencer for an N_CH analog pass-gate bank.
// Every channel change opens all gates for DEAD_CYCLES, then closes one gate
// and holds it SETTLE_CYCLES before pulsing done. sw_ctrl is registered and
// only ever moves 0->onehot or onehot->0.
// Optional feature macro: ASW_AUTOSCAN_EN (adds scan_en and IDLE dwell scan).
module analog_switch_sequencer #(
    parameter int unsigned N_CH          = 4,
    parameter int unsigned CW            = $clog2(N_CH),
    parameter int unsigned DEAD_CYCLES   = 3,
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter int unsigned DWELL_CYCLES  = 64
) (
    input  logic                        clk,
    input  logic                        rst,
`ifdef ASW_AUTOSCAN_EN
    input  logic                        scan_en,
`endif
    analog_switch_sequencer_if.slave    req,
    output logic [N_CH-1:0]             sw_ctrl,
    output logic [CW-1:0]               cur_chan,
    output logic                        cur_valid,
    output logic                        busy,
    output logic                        done,
    output logic                        err
);

    localparam int unsigned MAX_DS  = (DEAD_CYCLES > SETTLE_CYCLES) ? DEAD_CYCLES : SETTLE_CYCLES;
    localparam int unsigned MAX_CNT = (MAX_DS > DWELL_CYCLES) ? MAX_DS : DWELL_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BREAK = 2'd1,
        ST_MAKE  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]      tgt_q, tgt_d;
    logic               off_q, off_d;
    logic [N_CH-1:0]    sw_ctrl_q, sw_ctrl_d;
    logic [CW-1:0]      cur_chan_q, cur_chan_d;
    logic               cur_valid_q, cur_valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               ready_c;
    logic               accept_c;
    logic               in_range_c;
    logic [CW-1:0]      req_idx_c;
    logic               seq_start;
    logic               seq_off;
    logic [CW-1:0]      seq_chan;

    // Handshake decode; req_chan/req_off only matter on the accepting edge.
    always_comb begin
        ready_c    = (state_q == ST_IDLE) && !rst;
        accept_c   = req.req_valid && ready_c;
        in_range_c = 32'(req.req_chan) < N_CH;
        req_idx_c  = CW'(req.req_chan);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tgt_d       = tgt_q;
        off_d       = off_q;
        sw_ctrl_d   = sw_ctrl_q;
        cur_chan_d  = cur_chan_q;
        cur_valid_d = cur_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        seq_start   = 1'b0;
        seq_off     = 1'b0;
        seq_chan    = '0;

        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    cnt_d = '0;
                    if (!req.req_off && in_range_c && cur_valid_q && (req_idx_c == cur_chan_q)) begin
                        // Already closed on the requested channel: leave gates untouched.
                        done_d = 1'b1;
                    end else begin
                        seq_start = 1'b1;
                        seq_off   = req.req_off || !in_range_c;
                        seq_chan  = req_idx_c;
                        err_d     = !req.req_off && !in_range_c;
                    end
                end
`ifdef ASW_AUTOSCAN_EN
                else if (!scan_en) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_W'(DWELL_CYCLES)) begin
                    // Dwell expired: step to the next channel, or start at 0.
                    seq_start = 1'b1;
                    seq_off   = 1'b0;
                    if (!cur_valid_q || (cur_chan_q == CW'(N_CH - 1))) begin
                        seq_chan = '0;
                    end else begin
                        seq_chan = cur_chan_q + CW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end

            ST_BREAK: begin
                if (cnt_q == '0) begin
                    if (off_q) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        cnt_d   = '0;
                    end else begin
                        state_d    = ST_MAKE;
                        sw_ctrl_d  = N_CH'(1) << tgt_q;
                        cur_chan_d = tgt_q;
                        cnt_d      = CNT_W'(SETTLE_CYCLES - 1);
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            ST_MAKE: begin
                if (cnt_q == '0) begin
                    state_d     = ST_IDLE;
                    cur_valid_d = 1'b1;
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    cnt_d       = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            default: begin
                state_d     = ST_IDLE;
                sw_ctrl_d   = '0;
                cur_valid_d = 1'b0;
                busy_d      = 1'b0;
                cnt_d       = '0;
            end
        endcase

        // Any real sequence starts by opening every gate.
        if (seq_start) begin
            state_d     = ST_BREAK;
            sw_ctrl_d   = '0;
            cur_valid_d = 1'b0;
            busy_d      = 1'b1;
            cnt_d       = CNT_W'(DEAD_CYCLES - 1);
            tgt_d       = seq_chan;
            off_d       = seq_off;
        end
    end

    // State register; reset opens all gates on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            tgt_q       <= '0;
            off_q       <= 1'b0;
            sw_ctrl_q   <= '0;
            cur_chan_q  <= '0;
            cur_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tgt_q       <= tgt_d;
            off_q       <= off_d;
            sw_ctrl_q   <= sw_ctrl_d;
            cur_chan_q  <= cur_chan_d;
            cur_valid_q <= cur_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign req.req_ready = ready_c;
    assign sw_ctrl       = sw_ctrl_q;
    assign cur_chan      = cur_chan_q;
    assign cur_valid     = cur_valid_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;

endmodule

// File: tb/tb_analog_switch_sequencer.sv
// Bench for analog_switch_sequencer: directed and random requests scored
// against a timeline model (offset since accept -> expected outputs).
module tb_analog_switch_sequencer;

    localparam int N_CH   = 4;
    localparam int CW     = 2;
    localparam int DEAD   = 3;
    localparam int SETTLE = 8;
    localparam int DWELL  = 64;

    localparam int K_SAME = 0;
    localparam int K_CHAN = 1;
    localparam int K_OFF  = 2;

    typedef struct packed {
        logic [N_CH-1:0] sw;
        logic            busy;
        logic            done;
        logic            err;
        logic            cv;
        logic            rdy;
        logic [CW-1:0]   cc;
    } obs_t;

    logic            clk;
    logic            rst;
    logic [N_CH-1:0] sw_ctrl;
    logic [CW-1:0]   cur_chan;
    logic            cur_valid;
    logic            busy;
    logic            done;
    logic            err;
`ifdef ASW_AUTOSCAN_EN
    logic            scan_en;
`endif

    analog_switch_sequencer_if rif ();

    analog_switch_sequencer #(
        .N_CH          (N_CH),
        .CW            (CW),
        .DEAD_CYCLES   (DEAD),
        .SETTLE_CYCLES (SETTLE),
        .DWELL_CYCLES  (DWELL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef ASW_AUTOSCAN_EN
        .scan_en   (scan_en),
`endif
        .req       (rif),
        .sw_ctrl   (sw_ctrl),
        .cur_chan  (cur_chan),
        .cur_valid (cur_valid),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int gate_viol = 0;
    logic mon_en = 1'b0;
    logic [N_CH-1:0] prev_sw = '0;

    // Model state: which channel should be closed and settled.
    int   m_cur = 0;
    logic m_cv  = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Gate safety monitor: never two gates, never onehot->onehot.
    always @(negedge clk) begin
        if (mon_en) begin
            if ($countones(sw_ctrl) > 1) gate_viol++;
            if (prev_sw != '0 && sw_ctrl != '0 && prev_sw != sw_ctrl) gate_viol++;
            prev_sw = sw_ctrl;
        end
    end

    assert property (@(posedge clk) disable iff (!mon_en) $onehot0(sw_ctrl))
        else $error("FAIL gate_onehot0 sw=%b", sw_ctrl);

    function automatic int classify(input int chan, input logic off);
        if (!off && chan < N_CH && m_cv && chan == m_cur) return K_SAME;
        if (off || chan >= N_CH) return K_OFF;
        return K_CHAN;
    endfunction

    function automatic int seq_len(input int kind);
        if (kind == K_SAME) return 0;
        if (kind == K_CHAN) return DEAD + SETTLE;
        return DEAD;
    endfunction

    // Expected outputs i cycles after the accepting edge.
    function automatic obs_t predict(input int i, input int kind, input int chan, input logic bad);
        obs_t e;
        e = '0;
        case (kind)
            K_SAME: begin
                e.sw[chan] = 1'b1;
                e.done     = (i == 0);
                e.cv       = 1'b1;
            end
            K_CHAN: begin
                if (i < DEAD) begin
                    e.busy = 1'b1;
                end else begin
                    e.sw[chan] = 1'b1;
                    e.busy     = (i < DEAD + SETTLE);
                    e.done     = (i == DEAD + SETTLE);
                    e.cv       = (i >= DEAD + SETTLE);
                end
            end
            default: begin
                e.busy = (i < DEAD);
                e.done = (i == DEAD);
                e.err  = bad && (i == 0);
            end
        endcase
        e.rdy = !e.busy;
        e.cc  = e.cv ? CW'(chan) : '0;
        return e;
    endfunction

    task automatic issue(input int chan, input logic off);
        @(negedge clk);
        rif.req_valid = 1'b1;
        rif.req_chan  = 4'(chan);
        rif.req_off   = off;
        @(posedge clk);
        #1;
        rif.req_valid = 1'b0;
        rif.req_chan  = '0;
        rif.req_off   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rif.req_valid = 1'b0;
        rif.req_chan  = '0;
        rif.req_off   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (sw_ctrl !== '0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 ||
            cur_valid !== 1'b0 || cur_chan !== '0 || rif.req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold got sw=%b busy=%b done=%b err=%b cv=%b cc=%0d rdy=%b, want all 0",
                     sw_ctrl, busy, done, err, cur_valid, cur_chan, rif.req_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (rif.req_ready !== 1'b1 || sw_ctrl !== '0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release got rdy=%b sw=%b busy=%b, want rdy=1 sw=0 busy=0",
                     rif.req_ready, sw_ctrl, busy);
        end
        m_cur = 0;
        m_cv  = 1'b0;
        mon_en = 1'b1;
    endtask

    // One request scored cycle by cycle; n_cyc < 0 runs to one cycle past done.
    task automatic test_request(input string name, input int chan, input logic off, input int n_cyc);
        int   kind;
        int   last;
        logic bad;
        int   ech;
        obs_t e;
        obs_t got;
        kind = classify(chan, off);
        bad  = !off && chan >= N_CH;
        ech  = (kind == K_SAME) ? m_cur : chan;
        last = (n_cyc < 0) ? seq_len(kind) + 1 : n_cyc;
        issue(chan, off);
        for (int i = 0; i <= last; i++) begin
            @(negedge clk);
            e = predict(i, kind, ech, bad);
            got.sw   = sw_ctrl;
            got.busy = busy;
            got.done = done;
            got.err  = err;
            got.cv   = cur_valid;
            got.rdy  = rif.req_ready;
            got.cc   = e.cv ? cur_chan : '0;
            n_tests++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL %s cyc=%0d got sw=%b busy=%b done=%b err=%b cv=%b rdy=%b cc=%0d, want sw=%b busy=%b done=%b err=%b cv=%b rdy=%b cc=%0d",
                         name, i, got.sw, got.busy, got.done, got.err, got.cv, got.rdy, got.cc,
                         e.sw, e.busy, e.done, e.err, e.cv, e.rdy, e.cc);
            end
        end
        if (n_cyc < 0) begin
            if (kind == K_CHAN) begin
                m_cur = chan;
                m_cv  = 1'b1;
            end else if (kind == K_OFF) begin
                m_cv = 1'b0;
            end
        end
    endtask

    task automatic test_reset_mid_make();
        test_request("mid_make_pre", 3, 1'b0, DEAD + 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (sw_ctrl !== '0 || rif.req_ready !== 1'b1 || cur_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_make_reset got sw=%b rdy=%b cv=%b busy=%b, want sw=0 rdy=1 cv=0 busy=0",
                     sw_ctrl, rif.req_ready, cur_valid, busy);
        end
        m_cur = 0;
        m_cv  = 1'b0;
        test_request("after_reset", 2, 1'b0, -1);
    endtask

    task automatic test_random();
        int   chan;
        logic off;
        for (int n = 0; n < 25; n++) begin
            if (m_cv && $urandom_range(0, 3) == 0) chan = m_cur;
            else chan = int'($urandom_range(0, 7));
            off = ($urandom_range(0, 7) == 0);
            test_request("random", chan, off, -1);
        end
    endtask

`ifdef ASW_AUTOSCAN_EN
    task automatic test_autoscan();
        int   waited;
        logic found;
        int   exp_ch;
        test_request("scan_prep_off", 0, 1'b1, -1);
        scan_en = 1'b1;
        exp_ch = 0;
        for (int n = 0; n < 5; n++) begin
            waited = 0;
            found  = 1'b0;
            while (!found && waited < 200) begin
                @(negedge clk);
                waited++;
                if (done === 1'b1) found = 1'b1;
            end
            n_tests++;
            if (!found || waited != DWELL + DEAD + SETTLE + 1 || cur_chan !== CW'(exp_ch) || cur_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL autoscan_step%0d got found=%b gap=%0d chan=%0d cv=%b, want gap=%0d chan=%0d cv=1",
                         n, found, waited, cur_chan, cur_valid, DWELL + DEAD + SETTLE + 1, exp_ch);
            end
            exp_ch = (exp_ch + 1) % N_CH;
        end
        // External request during dwell takes precedence over the scan.
        repeat (20) @(negedge clk);
        rif.req_valid = 1'b1;
        rif.req_chan  = 4'd2;
        rif.req_off   = 1'b0;
        @(posedge clk);
        #1;
        rif.req_valid = 1'b0;
        rif.req_chan  = '0;
        waited = 0;
        found  = 1'b0;
        while (!found && waited < 200) begin
            @(negedge clk);
            waited++;
            if (done === 1'b1) found = 1'b1;
        end
        n_tests++;
        if (!found || waited != DEAD + SETTLE + 1 || cur_chan !== 2'd2) begin
            n_fail++;
            $display("FAIL autoscan_preempt got found=%b lat=%0d chan=%0d, want lat=%0d chan=2",
                     found, waited, cur_chan, DEAD + SETTLE + 1);
        end
        waited = 0;
        found  = 1'b0;
        while (!found && waited < 200) begin
            @(negedge clk);
            waited++;
            if (done === 1'b1) found = 1'b1;
        end
        n_tests++;
        if (!found || waited != DWELL + DEAD + SETTLE + 1 || cur_chan !== 2'd3) begin
            n_fail++;
            $display("FAIL autoscan_resume got found=%b gap=%0d chan=%0d, want gap=%0d chan=3",
                     found, waited, cur_chan, DWELL + DEAD + SETTLE + 1);
        end
        scan_en = 1'b0;
        m_cur = 3;
        m_cv  = 1'b1;
        test_request("post_scan", 1, 1'b0, -1);
    endtask
`endif

    task automatic test_gate_safety();
        n_tests++;
        if (gate_viol != 0) begin
            n_fail++;
            $display("FAIL gate_safety got %0d violations, want 0", gate_viol);
        end
    endtask

    initial begin
`ifdef ASW_AUTOSCAN_EN
        scan_en = 1'b0;
`endif
        test_reset();
        test_request("first_chan2", 2, 1'b0, -1);
        test_request("change_chan1", 1, 1'b0, -1);
        test_request("same_chan1", 1, 1'b0, -1);
        test_request("out_of_range7", 7, 1'b0, -1);
        test_request("off_when_open", 0, 1'b1, -1);
        test_reset_mid_make();
        test_random();
`ifdef ASW_AUTOSCAN_EN
        test_autoscan();
`endif
        test_gate_safety();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
